// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory types plus the arbiter state, grant and captured-request types.
// The optional perf counters are enabled with CACHE_ARB_PERF_COUNTERS_EN.
package cache_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    localparam int PERF_W = 32;

    // Line request frozen at grant time; pmem is driven only from this.
    typedef struct packed {
        lc3b_word  addr;
        lc3b_burst wdata;
        logic      write;
    } line_req_t;

endpackage

// File: rtl/cache_arbiter_perf_counter.sv
// Single saturating event counter; only built when CACHE_ARB_PERF_COUNTERS_EN is defined.
`ifdef CACHE_ARB_PERF_COUNTERS_EN
module arb_perf_counter
    import cache_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule
`endif

// File: rtl/cache_arbiter.sv
// Arbitrates one line-burst memory port between the I-cache and D-cache, one transaction at a time.
// Define CACHE_ARB_PERF_COUNTERS_EN to build the grant/conflict counters; otherwise the perf ports are 0.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_read,
    input  logic [15:0]          i_address,
    output logic [127:0]         i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [15:0]          d_address,
    input  logic [127:0]         d_wdata,
    output logic [127:0]         d_rdata,
    output logic                 d_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    output logic [127:0]         pmem_wdata,
    input  logic [127:0]         pmem_rdata,
    input  logic                 pmem_resp,
    output logic [PERF_W-1:0]    perf_i_grants,
    output logic [PERF_W-1:0]    perf_d_grants,
    output logic [PERF_W-1:0]    perf_conflicts
);

    arb_state_t state, state_nxt;
    arb_grant_t last_grant, last_grant_nxt;
    arb_grant_t cool_grant;
    line_req_t  cap, cap_nxt;
    logic       cool_vld;
    logic       d_req, i_req_m, d_req_m, pick_d, done;

    always_comb begin
        d_req   = d_read | d_write;
        // The requester just served is ignored for one IDLE cycle so a stale request is not re-granted.
        i_req_m = i_read & ~(cool_vld && (cool_grant == GRANT_I));
        d_req_m = d_req  & ~(cool_vld && (cool_grant == GRANT_D));
        if (i_req_m && d_req_m)
            pick_d = (PRIORITY_MODE == 1) || (last_grant == GRANT_I);
        else
            pick_d = d_req_m;
        done = (state != IDLE) && pmem_resp;
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cap_nxt        = cap;
        case (state)
            IDLE: begin
                if (i_req_m || d_req_m) begin
                    if (pick_d) begin
                        state_nxt      = SERVE_D;
                        last_grant_nxt = GRANT_D;
                        cap_nxt        = '{addr: d_address, wdata: d_wdata, write: d_write};
                    end else begin
                        state_nxt      = SERVE_I;
                        last_grant_nxt = GRANT_I;
                        cap_nxt        = '{addr: i_address, wdata: '0, write: 1'b0};
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            cap        <= '0;
            cool_vld   <= 1'b0;
            cool_grant <= GRANT_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cap        <= cap_nxt;
            cool_vld   <= done;
            if (done)
                cool_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !cap.write);
    assign pmem_write   = (state == SERVE_D) && cap.write;
    assign pmem_address = cap.addr;
    assign pmem_wdata   = (state == SERVE_D) ? cap.wdata : '0;

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifdef CACHE_ARB_PERF_COUNTERS_EN
    logic grant_i_evt, grant_d_evt, conflict_evt;

    assign grant_i_evt  = (state == IDLE) && (state_nxt == SERVE_I);
    assign grant_d_evt  = (state == IDLE) && (state_nxt == SERVE_D);
    assign conflict_evt = ((state == SERVE_I) && d_req) || ((state == SERVE_D) && i_read);

    arb_perf_counter u_perf_i (.clk(clk), .rst_n(rst_n), .inc(grant_i_evt),  .count(perf_i_grants));
    arb_perf_counter u_perf_d (.clk(clk), .rst_n(rst_n), .inc(grant_d_evt),  .count(perf_d_grants));
    arb_perf_counter u_perf_c (.clk(clk), .rst_n(rst_n), .inc(conflict_evt), .count(perf_conflicts));
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: vector table plus hand sequences, scoreboard of expected completions.
// A second instance with fixed D priority is checked on the tie-from-reset case.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [15:0]  i_address = '0, d_address = '0;
    logic [127:0] d_wdata = '0, pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    logic [127:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [31:0]  perf_i_grants, perf_d_grants, perf_conflicts;

    logic [127:0] b_i_rdata, b_d_rdata, b_pmem_wdata;
    logic         b_i_resp, b_d_resp, b_pmem_read, b_pmem_write;
    logic [15:0]  b_pmem_address;
    logic [31:0]  b_perf_i, b_perf_d, b_perf_c;

    always #5 clk = ~clk;

    cache_arbiter #(.PRIORITY_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
    );

    cache_arbiter #(.PRIORITY_MODE(1)) dut_dprio (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(b_i_rdata), .i_resp(b_i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(b_d_rdata), .d_resp(b_d_resp),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_address(b_pmem_address),
        .pmem_wdata(b_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .perf_i_grants(b_perf_i), .perf_d_grants(b_perf_d), .perf_conflicts(b_perf_c)
    );

    typedef struct {
        bit           is_d;
        logic [15:0]  addr;
        bit           wr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    typedef struct {
        bit           ir;
        logic [15:0]  ia;
        bit           dr;
        bit           dw;
        logic [15:0]  da;
        logic [127:0] dwd;
        bit           d_first;
        bit           exp_rd;
        bit           exp_wr;
        logic [15:0]  exp_addr;
        logic [127:0] exp_wdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_chk = 0, n_fail = 0;
    int   i_resp_cnt = 0, d_resp_cnt = 0, i_seen = 0, d_seen = 0;
    int   i_hold = 0, d_hold = 0;
    int   mem_lat = 3, mem_cnt = 0;

    localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] W2 = 128'hDEADBEEFCAFEF00D1122334455667788;
    localparam logic [127:0] W3 = 128'h0F0F0F0FF0F0F0F05A5A5A5AA5A5A5A5;
    localparam logic [127:0] W4 = 128'hFEEDFACE00000000FFFFFFFF12345678;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        if (a == 16'h1230) return {16{8'hA5}};
        return {8{a}};
    endfunction

    function automatic exp_t mk(input bit is_d, input logic [15:0] a, input bit wr, input logic [127:0] wd);
        exp_t e;
        e.is_d = is_d; e.addr = a; e.wr = wr;
        e.wdata = is_d ? wd : '0;
        e.rdata = line_of(a);
        return e;
    endfunction

    function automatic vec_t mkv(input bit ir, input logic [15:0] ia, input bit dr, input bit dw,
                                 input logic [15:0] da, input logic [127:0] dwd, input bit d_first,
                                 input bit erd, input bit ewr, input logic [15:0] ea, input logic [127:0] ewd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.d_first = d_first;
        v.exp_rd = erd; v.exp_wr = ewr; v.exp_addr = ea; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Memory model: answers a strobe after mem_lat cycles with a one-cycle resp.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pmem_resp = 1'b0; mem_cnt = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0; mem_cnt = 0;
        end else if (pmem_read || pmem_write) begin
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line_of(pmem_address);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Completion monitor: pops the scoreboard on every resp.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_resp && d_resp) fail_msg("both_resp");
            if (i_resp || d_resp) begin
                if (sb.size() == 0) begin
                    fail_msg("unexpected_resp");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_src", {127'd0, d_resp}, {127'd0, e.is_d});
                    check("resp_addr", {112'd0, pmem_address}, {112'd0, e.addr});
                    check("resp_wr", {127'd0, pmem_write}, {127'd0, e.wr});
                    if (e.wr || !e.is_d) check("resp_wdata", pmem_wdata, e.wdata);
                    if (!e.wr) begin
                        check("resp_rdata", d_resp ? d_rdata : i_rdata, e.rdata);
                        check("rdata_bcast", i_rdata, d_rdata);
                    end
                end
                if (i_resp) i_resp_cnt++;
                if (d_resp) d_resp_cnt++;
            end
        end
    end

    // One clock; caches drop their request once resp was seen (after an optional hold).
    task automatic step();
        @(posedge clk);
        #1;
        if (i_resp_cnt != i_seen) begin
            if (i_hold > 0) i_hold--;
            else begin i_read = 1'b0; i_seen = i_resp_cnt; end
        end
        if (d_resp_cnt != d_seen) begin
            if (d_hold > 0) d_hold--;
            else begin d_read = 1'b0; d_write = 1'b0; d_seen = d_resp_cnt; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic run_until_empty(input int max);
        int k = 0;
        while (sb.size() != 0 && k < max) begin step(); k++; end
        if (sb.size() != 0) begin
            fail_msg("sb_timeout");
            sb.delete();
        end
    endtask

    task automatic wait_i(input int start, input string name);
        int k = 0;
        while (i_resp_cnt == start && k < 30) begin step(); k++; end
        if (i_resp_cnt == start) fail_msg(name);
    endtask

    task automatic single(input bit is_d, input logic [15:0] a, input bit wr, input logic [127:0] wd);
        if (is_d) begin d_read = !wr; d_write = wr; d_address = a; d_wdata = wd; end
        else begin i_read = 1'b1; i_address = a; end
        sb.push_back(mk(is_d, a, wr, wd));
        run_until_empty(40);
        idle(3);
    endtask

    initial begin
        vecs[0] = mkv(1, 16'h1230, 0, 0, 16'h0000, '0, 0, 1, 0, 16'h1230, '0);
        vecs[1] = mkv(0, 16'h0000, 0, 1, 16'h4000, W1, 0, 0, 1, 16'h4000, W1);
        vecs[2] = mkv(0, 16'h0000, 1, 0, 16'h2000, '0, 0, 1, 0, 16'h2000, '0);
        vecs[3] = mkv(0, 16'h0000, 1, 1, 16'h3000, W2, 0, 0, 1, 16'h3000, W2);
        vecs[4] = mkv(1, 16'h0100, 1, 0, 16'h0200, '0, 0, 1, 0, 16'h0100, '0);
        vecs[5] = mkv(1, 16'h0500, 0, 0, 16'h0000, '0, 0, 1, 0, 16'h0500, '0);
        vecs[6] = mkv(1, 16'h0600, 0, 1, 16'h0700, W3, 1, 0, 1, 16'h0700, W3);
        vecs[7] = mkv(1, 16'h0800, 1, 0, 16'h0900, '0, 1, 1, 0, 16'h0900, '0);

        // Reset state
        #3;
        check("rst_pmem_read", {127'd0, pmem_read}, '0);
        check("rst_pmem_write", {127'd0, pmem_write}, '0);
        check("rst_pmem_addr", {112'd0, pmem_address}, '0);
        check("rst_pmem_wdata", pmem_wdata, '0);
        check("rst_resp", {126'd0, i_resp, d_resp}, '0);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_perf", {32'd0, perf_i_grants, perf_d_grants, perf_conflicts}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Tie straight out of reset: RR serves I first, fixed priority serves D first
        i_read = 1'b1; i_address = 16'h0A00;
        d_read = 1'b1; d_address = 16'h0B00;
        sb.push_back(mk(0, 16'h0A00, 0, '0));
        sb.push_back(mk(1, 16'h0B00, 0, '0));
        step();
        check("tie_rr_rd", {127'd0, pmem_read}, 128'd1);
        check("tie_rr_addr", {112'd0, pmem_address}, {112'd0, 16'h0A00});
        check("tie_dprio_rd", {127'd0, b_pmem_read}, 128'd1);
        check("tie_dprio_addr", {112'd0, b_pmem_address}, {112'd0, 16'h0B00});
        wait_i(i_resp_cnt, "tie_i_resp");
        check("tie_gap_idle", {126'd0, pmem_read, pmem_write}, '0);
        step();
        check("tie_d_rd", {127'd0, pmem_read}, 128'd1);
        check("tie_d_addr", {112'd0, pmem_address}, {112'd0, 16'h0B00});
        run_until_empty(40);
        idle(3);

        // Vector table: first grant after a request from IDLE, then completions via scoreboard
        for (int v = 0; v < 8; v++) begin
            i_read = vecs[v].ir; i_address = vecs[v].ia;
            d_read = vecs[v].dr; d_write = vecs[v].dw; d_address = vecs[v].da; d_wdata = vecs[v].dwd;
            if (vecs[v].ir && (vecs[v].dr || vecs[v].dw)) begin
                if (vecs[v].d_first) begin
                    sb.push_back(mk(1, vecs[v].da, vecs[v].dw, vecs[v].dwd));
                    sb.push_back(mk(0, vecs[v].ia, 0, '0));
                end else begin
                    sb.push_back(mk(0, vecs[v].ia, 0, '0));
                    sb.push_back(mk(1, vecs[v].da, vecs[v].dw, vecs[v].dwd));
                end
            end else if (vecs[v].ir) begin
                sb.push_back(mk(0, vecs[v].ia, 0, '0));
            end else begin
                sb.push_back(mk(1, vecs[v].da, vecs[v].dw, vecs[v].dwd));
            end
            step();
            check($sformatf("v%0d_rd", v), {127'd0, pmem_read}, {127'd0, vecs[v].exp_rd});
            check($sformatf("v%0d_wr", v), {127'd0, pmem_write}, {127'd0, vecs[v].exp_wr});
            check($sformatf("v%0d_addr", v), {112'd0, pmem_address}, {112'd0, vecs[v].exp_addr});
            check($sformatf("v%0d_wdata", v), pmem_wdata, vecs[v].exp_wdata);
            run_until_empty(60);
            idle(3);
        end

        // Stale request held one cycle past resp is masked, not re-granted
        i_read = 1'b1; i_address = 16'h0A10; i_hold = 1;
        sb.push_back(mk(0, 16'h0A10, 0, '0));
        wait_i(i_resp_cnt, "cool_i_resp");
        check("cool_idle1", {126'd0, pmem_read, pmem_write}, '0);
        step();
        check("cool_idle2", {126'd0, pmem_read, pmem_write}, '0);
        idle(6);

        // Back-to-back: I held 2 cycles past resp with D pending -> D next
        i_read = 1'b1; i_address = 16'h0D00;
        sb.push_back(mk(0, 16'h0D00, 0, '0));
        step();
        d_read = 1'b1; d_address = 16'h0E00; i_hold = 2;
        sb.push_back(mk(1, 16'h0E00, 0, '0));
        wait_i(i_resp_cnt, "b2b_i_resp");
        check("b2b_gap_idle", {126'd0, pmem_read, pmem_write}, '0);
        step();
        check("b2b_d_rd", {127'd0, pmem_read}, 128'd1);
        check("b2b_d_addr", {112'd0, pmem_address}, {112'd0, 16'h0E00});
        run_until_empty(40);
        idle(4);

        // Writeback data frozen at grant
        d_write = 1'b1; d_address = 16'h6000; d_wdata = W4;
        sb.push_back(mk(1, 16'h6000, 1, W4));
        step();
        check("wb_wr", {127'd0, pmem_write}, 128'd1);
        check("wb_wdata0", pmem_wdata, W4);
        d_wdata = ~W4; d_address = 16'hFFFF;
        step();
        check("wb_wdata1", pmem_wdata, W4);
        check("wb_addr1", {112'd0, pmem_address}, {112'd0, 16'h6000});
        run_until_empty(40);
        idle(3);

        // Async reset in the middle of a writeback
        d_write = 1'b1; d_address = 16'h7000; d_wdata = W2;
        sb.push_back(mk(1, 16'h7000, 1, W2));
        step();
        step();
        check("abort_pre_wr", {127'd0, pmem_write}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr", {127'd0, pmem_write}, '0);
        check("abort_rd", {127'd0, pmem_read}, '0);
        check("abort_resp", {126'd0, i_resp, d_resp}, '0);
`ifdef CACHE_ARB_PERF_COUNTERS_EN
        check("abort_perf", {32'd0, perf_i_grants, perf_d_grants, perf_conflicts}, '0);
`endif
        d_write = 1'b0;
        sb.delete();
        i_seen = i_resp_cnt; d_seen = d_resp_cnt; i_hold = 0; d_hold = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        i_read = 1'b1; i_address = 16'h0C00;
        sb.push_back(mk(0, 16'h0C00, 0, '0));
        step();
        check("post_rst_rd", {127'd0, pmem_read}, 128'd1);
        check("post_rst_addr", {112'd0, pmem_address}, {112'd0, 16'h0C00});
        run_until_empty(40);
        idle(3);

        // Perf traffic since reset: 5 I, 3 D, one 4-cycle overlap
        single(0, 16'h1100, 0, '0);
        single(0, 16'h1200, 0, '0);
        single(0, 16'h1300, 0, '0);
        mem_lat = 4;
        i_read = 1'b1; i_address = 16'h1400;
        sb.push_back(mk(0, 16'h1400, 0, '0));
        step();
        d_read = 1'b1; d_address = 16'h1500;
        sb.push_back(mk(1, 16'h1500, 0, '0));
        run_until_empty(40);
        idle(3);
        mem_lat = 3;
        single(1, 16'h1600, 0, '0);
        single(1, 16'h1700, 1, W3);
`ifdef CACHE_ARB_PERF_COUNTERS_EN
        check("perf_i", {96'd0, perf_i_grants}, 128'd5);
        check("perf_d", {96'd0, perf_d_grants}, 128'd3);
        check("perf_conf", {96'd0, perf_conflicts}, 128'd4);
`else
        check("perf_tied", {32'd0, perf_i_grants, perf_d_grants, perf_conflicts}, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
